fetch_ctrl: RTL and testbench
=============================

FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries (power of two, 2..8).
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port imem_req_valid  output  1  fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1  memory accepts request.
REQ-007 SHALL have port imem_req_addr  output  32  word-aligned fetch address.
REQ-008 SHALL have port imem_rsp_valid  input  1  response data valid; one per accepted request, in order, latency >= 1 cycle.
REQ-009 SHALL have port imem_rsp_data  input  32  instruction word, big-endian byte order.
REQ-010 SHALL have port redirect_valid  input  1  branch/jump redirect strobe.
REQ-011 SHALL have port redirect_pc  input  32  redirect target.
REQ-012 SHALL have port instr_valid  output  1  instruction available to decode/ImmGen.
REQ-013 SHALL have port instr_ready  input  1  decode accepts instruction.
REQ-014 SHALL have port instr  output  32  little-endian (byte-swapped) instruction.
REQ-015 SHALL have port instr_pc  output  32  address of instr.

Function
REQ-016 SHALL implement states IDLE, RUN, FLUSH; IDLE -> RUN unconditionally one cycle after reset release.
REQ-017 SHALL assert imem_req_valid only in RUN and only when outstanding + buffered < DEPTH (credit rule); a request completes when imem_req_valid && imem_req_ready.
REQ-018 SHALL hold imem_req_addr stable while imem_req_valid is high and not accepted; advance fetch PC by 4 on each accepted request.
REQ-019 SHALL store each non-stale response with its PC in a DEPTH-entry FIFO; response writes never overflow (guaranteed by REQ-017).
REQ-020 SHALL present the FIFO head on instr/instr_pc with instr_valid = FIFO non-empty; byte swap applied on write, zero extra latency on read.
REQ-021 SHALL allow simultaneous FIFO write and read when full or empty (empty: response visible on instr next cycle, no bypass).
REQ-022 On redirect_valid, SHALL next cycle: flush FIFO, set fetch PC to {redirect_pc[31:2],2'b00}, mark all in-flight requests (including one accepted in the redirect cycle) stale.
REQ-023 SHALL enter FLUSH after redirect if stale count > 0, else stay RUN; in FLUSH drop stale responses, issue no requests; FLUSH -> RUN when stale count reaches 0.
REQ-024 SHALL drop a response arriving in the redirect cycle; a decode handshake in the redirect cycle completes normally.
REQ-025 SHALL honour a new redirect in FLUSH: update target, add the cycle's newly stale requests to the count, remain in FLUSH.
REQ-026 SHALL wrap fetch PC modulo 2^32 (32'hFFFF_FFFC + 4 = 0).
REQ-027 SHALL size outstanding/stale counters to hold DEPTH without overflow.

Reset
REQ-028 SHALL, when rst is low at a clock edge, set state IDLE, fetch PC RESET_PC, FIFO empty, counters 0, imem_req_valid 0, instr_valid 0; instr and instr_pc 0.
REQ-029 SHALL treat reset mid-operation as absolute: responses to pre-reset requests arriving after reset are the integrator's responsibility (memory reset together).

Structure
REQ-030 SHALL take ENDIAN_SWP_32 and the state encoding macros from the shared types.vh.
REQ-031 SHALL instantiate one sub-module, fetch_fifo (DEPTH x 64-bit PC+instr sync FIFO).

Verification
REQ-032 Zero-latency-ready memory, 1-cycle response, instr_ready=1: words 0x13000000,0x93001000 -> instr 0x00000013@PC 0x0, 0x00100093@PC 0x4, one per cycle steady state.
REQ-033 instr_ready=0 for 10 cycles -> exactly 2 requests issued (0x0,0x4), imem_req_valid low thereafter, no data lost on release.
REQ-034 Redirect to 0x0000_0102 with 2 outstanding -> FLUSH drops 2 responses, next request addr 0x100, first instr_pc 0x100.
REQ-035 Redirect in same cycle as response and decode handshake -> handshake instr consumed, response dropped, no stale instr emitted.
REQ-036 RESET_PC=32'hFFFF_FFFC -> request addrs 0xFFFFFFFC then 0x0.
REQ-037 imem_req_ready random 50%, response latency random 1..5 -> instr_pc strictly sequential, byte-swap correct against model.

Source files
------------

// File: rtl/fetch_ctrl_pkg.sv
// Shared types for the instruction fetch controller.
//   fetch_state_e  : controller FSM encoding (idle after reset, running, flushing stale responses)
//   fetch_entry_t  : one instruction buffer entry, fetch PC plus byte-swapped instruction word
//   CntW           : width of the in-flight / stale / occupancy counters (holds up to 8)
//   endian_swp_32  : big-endian memory word to little-endian instruction byte swap
package fetch_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StFlush = 2'd2
  } fetch_state_e;

  // Buffer depth is capped at 8, so 4 bits hold every counter value without wrapping.
  localparam int unsigned CntW = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] endian_swp_32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous instruction buffer: DEPTH entries of {pc, instr}.
//   clk_i, rst_ni : clock and synchronous active-low reset
//   flush_i       : drop all contents next cycle (wins over write and read)
//   wr_en_i       : push wr_data_i; accepted when not full or when a read happens alongside
//   rd_en_i       : pop the head; ignored when empty
//   rd_data_o     : current head, no extra read latency
//   empty_o       : buffer holds nothing
//   count_o       : current occupancy
module fetch_fifo
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  input  logic            wr_en_i,
  input  fetch_entry_t    wr_data_i,
  input  logic            rd_en_i,
  output fetch_entry_t    rd_data_o,
  output logic            empty_o,
  output logic [CntW-1:0] count_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  fetch_entry_t    mem_q [DEPTH];
  fetch_entry_t    mem_d [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            full;
  logic            wr_ok;
  logic            rd_ok;

  assign empty_o   = (count_q == '0);
  assign full      = (count_q == CntW'(DEPTH));
  assign count_o   = count_q;
  assign rd_data_o = mem_q[rd_ptr_q];

  assign rd_ok = rd_en_i && !empty_o;
  // A full buffer can still take a write when the head leaves in the same cycle.
  assign wr_ok = wr_en_i && (!full || rd_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_ptr_q] = wr_data_i;
        // DEPTH is a power of two, so the pointer wraps on its own.
        wr_ptr_d        = wr_ptr_q + PtrW'(1);
      end
      if (rd_ok) begin
        rd_ptr_d = rd_ptr_q + PtrW'(1);
      end
      unique case ({wr_ok, rd_ok})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Issues word fetches to instruction memory under a credit limit so that every response has a
// buffer slot, byte-swaps returned words into a small FIFO and presents them to decode. A
// redirect restarts fetch at a new target, flushes the buffer and discards responses to
// requests that were in flight at the time.
//   clk, rst                       : clock, synchronous active-low reset
//   imem_req_valid/ready/addr      : fetch request channel (addr held until accepted)
//   imem_rsp_valid/data            : in-order responses, big-endian words
//   redirect_valid/redirect_pc     : branch/jump redirect strobe and target
//   instr_valid/ready, instr/pc    : decode channel, little-endian instruction and its address
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc
);

  fetch_state_e    state_q, state_d;
  logic [31:0]     pc_q, pc_d;          // next address to request
  logic [31:0]     rsp_pc_q, rsp_pc_d;  // address belonging to the next live response
  logic [CntW-1:0] outst_q, outst_d;    // live requests awaiting a response
  logic [CntW-1:0] stale_q, stale_d;    // requests whose responses must be discarded

  logic [CntW-1:0] fifo_count;
  logic            fifo_empty;
  fetch_entry_t    fifo_head;
  fetch_entry_t    fifo_wr_data;
  logic            fifo_wr;
  logic            fifo_rd;

  logic            req_fire;
  logic            rsp_stale;
  logic            rsp_live;
  logic [31:0]     redirect_target;

  // Credit rule: never have more requests in flight than free buffer slots.
  assign imem_req_valid = (state_q == StRun) && ((outst_q + fifo_count) < CntW'(DEPTH));
  assign imem_req_addr  = pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses arrive in order, so all stale ones come before any live one.
  assign rsp_stale = imem_rsp_valid && (stale_q != '0);
  assign rsp_live  = imem_rsp_valid && (stale_q == '0);

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // A live response landing in the redirect cycle belongs to the old path and is dropped.
  assign fifo_wr      = rsp_live && !redirect_valid;
  assign fifo_wr_data = '{pc: rsp_pc_q, instr: endian_swp_32(imem_rsp_data)};
  assign fifo_rd      = instr_valid && instr_ready;

  assign instr_valid = !fifo_empty;
  assign instr       = fifo_empty ? 32'h0 : fifo_head.instr;
  assign instr_pc    = fifo_empty ? 32'h0 : fifo_head.pc;

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    rsp_pc_d = rsp_pc_q;
    outst_d  = outst_q + CntW'(req_fire) - CntW'(rsp_live);
    stale_d  = stale_q - CntW'(rsp_stale);

    if (req_fire) begin
      pc_d = pc_q + 32'd4;
    end
    if (rsp_live) begin
      rsp_pc_d = rsp_pc_q + 32'd4;
    end

    unique case (state_q)
      StIdle:  state_d = StRun;
      StRun:   state_d = StRun;
      StFlush: begin
        if (stale_d == '0) begin
          state_d = StRun;
        end
      end
      default: state_d = StIdle;
    endcase

    // Everything still in flight, including a request accepted right now, turns stale.
    // A response arriving now retires one in-flight request whichever kind it was.
    if (redirect_valid) begin
      pc_d     = redirect_target;
      rsp_pc_d = redirect_target;
      outst_d  = '0;
      stale_d  = stale_q + outst_q + CntW'(req_fire) - CntW'(imem_rsp_valid);
      state_d  = (stale_d != '0) ? StFlush : StRun;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q  <= '0;
      stale_q  <= '0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q  <= outst_d;
      stale_q  <= stale_d;
    end
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk_i    (clk),
    .rst_ni   (rst),
    .flush_i  (redirect_valid),
    .wr_en_i  (fifo_wr),
    .wr_data_i(fifo_wr_data),
    .rd_en_i  (fifo_rd),
    .rd_data_o(fifo_head),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count)
  );

`ifndef SYNTHESIS
  credit_a: assert property (@(posedge clk) disable iff (!rst)
    (outst_q + fifo_count) <= CntW'(DEPTH));
  stale_in_flush_a: assert property (@(posedge clk) disable iff (!rst)
    (stale_q != '0) |-> (state_q == StFlush));
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic [31:0] instr;
  logic [31:0] instr_pc;

  // Second instance only exercises the wrapping reset PC.
  logic        w_imem_req_valid;
  logic        w_imem_req_ready = 1'b1;
  logic [31:0] w_imem_req_addr;
  logic        w_imem_rsp_valid = 1'b0;
  logic [31:0] w_imem_rsp_data = 32'h0;
  logic        w_redirect_valid = 1'b0;
  logic [31:0] w_redirect_pc = 32'h0;
  logic        w_instr_valid;
  logic        w_instr_ready = 1'b0;
  logic [31:0] w_instr;
  logic [31:0] w_instr_pc;

  fetch_ctrl dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_req_addr (imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data (imem_rsp_data),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc)
  );

  fetch_ctrl #(
    .RESET_PC(32'hFFFF_FFFC)
  ) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .imem_req_valid(w_imem_req_valid),
    .imem_req_ready(w_imem_req_ready),
    .imem_req_addr (w_imem_req_addr),
    .imem_rsp_valid(w_imem_rsp_valid),
    .imem_rsp_data (w_imem_rsp_data),
    .redirect_valid(w_redirect_valid),
    .redirect_pc   (w_redirect_pc),
    .instr_valid   (w_instr_valid),
    .instr_ready   (w_instr_ready),
    .instr         (w_instr),
    .instr_pc      (w_instr_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  typedef struct {
    logic [31:0] tgt;
    logic [31:0] tgt2;
    bit          twice;
    int unsigned lat;
    int          pre;
    logic [31:0] exp_pc;
  } rdv_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          n_fire = 0;
  int          n_hs = 0;
  int          n_rsp = 0;
  bit          coincide = 1'b0;
  int          ready_mode = 0;
  int unsigned lat_min = 1;
  int unsigned lat_max = 1;
  logic [31:0] exp_req_pc = 32'h0;
  int          last_due = 0;
  pend_t       pend[$];
  exp_t        exp_q[$];
  exp_t        e_m;
  int          due_m;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h1300_0000;
    if (a == 32'h4) return 32'h9300_1000;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    redirect_valid = 1'b0;
    tick(3);
    rst = 1'b1;
  endtask

  task automatic wait_sig(input bit use_instr, input string nm);
    int i;
    i = 0;
    while (i < 60 && !(use_instr ? instr_valid : imem_req_valid)) begin
      tick(1);
      i++;
    end
    check(nm, 32'(use_instr ? instr_valid : imem_req_valid), 32'd1);
  endtask

  // Memory model and scoreboard: runs on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      pend.delete();
      exp_q.delete();
      exp_req_pc     = 32'h0;
      last_due       = 0;
      n_fire         = 0;
      n_hs           = 0;
      n_rsp          = 0;
      coincide       = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_req_ready = 1'b1;
    end else begin
      imem_req_ready = (ready_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (pend.size() != 0 && pend[0].due <= cyc) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = mem_word(pend[0].addr);
        void'(pend.pop_front());
        n_rsp++;
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
      end
      if (instr_valid && instr_ready) begin
        n_hs++;
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL instr_unexpected: got pc %h, none expected", instr_pc);
        end else begin
          e_m = exp_q.pop_front();
          check("instr_pc", instr_pc, e_m.pc);
          check("instr_data", instr, e_m.ins);
        end
      end
      if (redirect_valid && imem_rsp_valid && instr_valid && instr_ready) coincide = 1'b1;
      if (imem_req_valid && imem_req_ready) begin
        check("req_addr", imem_req_addr, exp_req_pc);
        n_fire++;
        due_m = cyc + int'($urandom_range(lat_min, lat_max));
        if (due_m <= last_due) due_m = last_due + 1;
        last_due = due_m;
        pend.push_back('{addr: imem_req_addr, due: due_m});
        if (!redirect_valid) exp_q.push_back('{pc: exp_req_pc, ins: bswap(mem_word(exp_req_pc))});
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (redirect_valid) begin
        exp_q.delete();
        exp_req_pc = {redirect_pc[31:2], 2'b00};
      end
    end
  end

  rdv_t vecs[5];
  int   hs0;
  int   r0;

  initial begin
    vecs[0] = '{tgt: 32'h0000_1003, tgt2: 32'h0, twice: 1'b0, lat: 3, pre: 2,
                exp_pc: 32'h0000_1000};
    vecs[1] = '{tgt: 32'hFFFF_FFFE, tgt2: 32'h0, twice: 1'b0, lat: 1, pre: 5,
                exp_pc: 32'hFFFF_FFFC};
    vecs[2] = '{tgt: 32'h0000_0200, tgt2: 32'h0000_0301, twice: 1'b1, lat: 5, pre: 4,
                exp_pc: 32'h0000_0300};
    vecs[3] = '{tgt: 32'h8000_0007, tgt2: 32'h0000_0040, twice: 1'b1, lat: 2, pre: 1,
                exp_pc: 32'h0000_0040};
    vecs[4] = '{tgt: 32'h0000_4446, tgt2: 32'h0, twice: 1'b0, lat: 4, pre: 7,
                exp_pc: 32'h0000_4444};

    // Reset state.
    rst = 1'b0;
    tick(3);
    check("rst_req_valid", 32'(imem_req_valid), 32'd0);
    check("rst_instr_valid", 32'(instr_valid), 32'd0);
    check("rst_instr", instr, 32'h0);
    check("rst_instr_pc", instr_pc, 32'h0);
    check("rst_wrap_req_valid", 32'(w_imem_req_valid), 32'd0);

    // Release with decode stalled: credit limit holds fetch at two requests.
    rst = 1'b1;
    check("idle_req_valid", 32'(imem_req_valid), 32'd0);
    tick(1);
    check("run_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_addr", imem_req_addr, 32'h0);
    check("wrap_valid0", 32'(w_imem_req_valid), 32'd1);
    check("wrap_addr0", w_imem_req_addr, 32'hFFFF_FFFC);
    tick(1);
    check("wrap_valid1", 32'(w_imem_req_valid), 32'd1);
    check("wrap_addr1", w_imem_req_addr, 32'h0);
    tick(1);
    check("wrap_credit", 32'(w_imem_req_valid), 32'd0);
    tick(8);
    check("stall_fires", 32'(n_fire), 32'd2);
    check("stall_req_valid", 32'(imem_req_valid), 32'd0);
    check("stall_instr_valid", 32'(instr_valid), 32'd1);
    hs0 = n_hs;
    instr_ready = 1'b1;
    tick(4);
    check("stall_release_hs", 32'((n_hs - hs0) >= 2), 32'd1);

    // Steady stream, zero-wait memory, one-cycle responses.
    do_reset();
    tick(1);
    check("seq_req_valid", 32'(imem_req_valid), 32'd1);
    check("seq_req_addr", imem_req_addr, 32'h0);
    tick(2);
    check("seq_i0_valid", 32'(instr_valid), 32'd1);
    check("seq_i0", instr, 32'h0000_0013);
    check("seq_i0_pc", instr_pc, 32'h0);
    tick(1);
    check("seq_i1_valid", 32'(instr_valid), 32'd1);
    check("seq_i1", instr, 32'h0010_0093);
    check("seq_i1_pc", instr_pc, 32'h4);

    // Redirect coinciding with a response and a decode handshake.
    do_reset();
    tick(3);
    check("coin_instr_valid", 32'(instr_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0802;
    tick(1);
    redirect_valid = 1'b0;
    check("coin_seen", 32'(coincide), 32'd1);
    check("coin_flushed", 32'(instr_valid), 32'd0);
    wait_sig(1'b0, "coin_req_timeout");
    check("coin_req_addr", imem_req_addr, 32'h0000_0800);
    wait_sig(1'b1, "coin_instr_timeout");
    check("coin_instr_pc", instr_pc, 32'h0000_0800);
    check("coin_instr", instr, bswap(mem_word(32'h0000_0800)));

    // Redirect with two requests outstanding: both responses are discarded.
    lat_min = 4;
    lat_max = 4;
    do_reset();
    tick(3);
    check("fl_credit", 32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    tick(1);
    redirect_valid = 1'b0;
    r0 = n_rsp;
    check("fl_no_req", 32'(imem_req_valid), 32'd0);
    wait_sig(1'b0, "fl_req_timeout");
    check("fl_dropped", 32'(n_rsp - r0), 32'd2);
    check("fl_req_addr", imem_req_addr, 32'h0000_0100);
    wait_sig(1'b1, "fl_instr_timeout");
    check("fl_instr_pc", instr_pc, 32'h0000_0100);
    check("fl_instr", instr, bswap(mem_word(32'h0000_0100)));

    // Table of redirects: alignment, wrap near the top, back-to-back redirects.
    foreach (vecs[k]) begin
      lat_min = vecs[k].lat;
      lat_max = vecs[k].lat;
      tick(vecs[k].pre);
      redirect_valid = 1'b1;
      redirect_pc    = vecs[k].tgt;
      tick(1);
      if (vecs[k].twice) begin
        redirect_pc = vecs[k].tgt2;
        tick(1);
      end
      redirect_valid = 1'b0;
      check("tab_flushed", 32'(instr_valid), 32'd0);
      wait_sig(1'b0, "tab_req_timeout");
      check("tab_req_addr", imem_req_addr, vecs[k].exp_pc);
      wait_sig(1'b1, "tab_instr_timeout");
      check("tab_instr_pc", instr_pc, vecs[k].exp_pc);
      check("tab_instr", instr, bswap(mem_word(vecs[k].exp_pc)));
    end

    // Random memory backpressure and latency, random decode stalls and redirects.
    ready_mode = 1;
    lat_min    = 1;
    lat_max    = 5;
    hs0        = n_hs;
    for (int i = 0; i < 1500; i++) begin
      instr_ready    = ($urandom_range(0, 9) < 7);
      redirect_valid = ($urandom_range(0, 63) == 0);
      redirect_pc    = $urandom;
      tick(1);
    end
    redirect_valid = 1'b0;
    ready_mode     = 0;
    instr_ready    = 1'b1;
    tick(20);
    check("rand_progress", 32'((n_hs - hs0) >= 100), 32'd1);
    check("wrap_no_instr", 32'(w_instr_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
